// File: rtl/yas_router_pkg.sv
// Shared definitions for the yas_router_n packet router: input FSM encoding and header field layout.
// The CRC state only exists when YAS_ROUTER_CRC_CHECK_EN is defined.
package yas_router_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_DROP    = 2'd2;
`ifdef YAS_ROUTER_CRC_CHECK_EN
  localparam logic [1:0] ST_CRC     = 2'd3;
`endif

  // Header byte is {len, addr}: addr in the low ADDR_W bits, len above it.
  localparam int HDR_ADDR_LSB = 0;

  function automatic int hdr_len_lsb(input int addr_w);
    return HDR_ADDR_LSB + addr_w;
  endfunction

endpackage

// File: rtl/yas_fifo_commit.sv
// Per-channel FIFO with a speculative write pointer (packet being stored) and a committed
// write pointer (visible to the reader); rollback discards everything since the last commit.
module yas_fifo_commit #(
  parameter int DATA_WIDTH = 8,
  parameter int AW         = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  commit,
  input  logic                  rollback,
  input  logic                  rd_en,
  output logic                  full,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int DEPTH = 2 ** AW;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           rd_ptr;
  logic [AW:0]           wr_ptr_spec;
  logic [AW:0]           wr_ptr_cmt;
  logic [AW:0]           wr_ptr_spec_nxt;
  logic                  push;
  logic                  pop;

  // Extra MSB separates full (MSBs differ) from empty (pointers equal).
  assign full     = (wr_ptr_spec[AW] != rd_ptr[AW]) && (wr_ptr_spec[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_valid = (wr_ptr_cmt != rd_ptr);
  assign rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

  assign push            = wr_en & ~full;
  assign pop             = rd_en & rd_valid;
  assign wr_ptr_spec_nxt = wr_ptr_spec + (AW+1)'(push);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rd_ptr      <= '0;
      wr_ptr_spec <= '0;
      wr_ptr_cmt  <= '0;
    end else begin
      rd_ptr <= rd_ptr + (AW+1)'(pop);
      if (rollback) wr_ptr_spec <= wr_ptr_cmt;
      else          wr_ptr_spec <= wr_ptr_spec_nxt;
      // Commit includes a byte written in the same cycle.
      if (commit)   wr_ptr_cmt  <= wr_ptr_spec_nxt;
    end
  end

  // NOTE: storage is deliberately not reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_spec[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/yas_router_n.sv
// Packet router: one inbound byte stream, NUM_CH outbound channels selected by a header address.
// Optional trailing-XOR packet check when YAS_ROUTER_CRC_CHECK_EN is defined.
module yas_router_n
  import yas_router_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 3,
  parameter int ADDR_W     = 2,
  parameter int FIFO_AW    = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         data_in_req,
  output logic                         data_in_ack,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]            data_out_req,
  input  logic [NUM_CH-1:0]            data_out_ack,
  input  logic [$clog2(NUM_CH)-1:0]    config_addr,
  input  logic [ADDR_W-1:0]            config_data,
  input  logic                         config_en
);
  localparam int CH_W    = $clog2(NUM_CH);
  localparam int LEN_LSB = hdr_len_lsb(ADDR_W);
  localparam int LEN_W   = DATA_WIDTH - LEN_LSB;
  localparam int REM_W   = LEN_W + 1;
`ifdef YAS_ROUTER_CRC_CHECK_EN
  localparam logic [REM_W-1:0] CRC_EXTRA = REM_W'(1);
`else
  localparam logic [REM_W-1:0] CRC_EXTRA = '0;
`endif

  logic [1:0]        state, state_nxt;
  logic [REM_W-1:0]  rem, rem_nxt;
  logic [CH_W-1:0]   dest, dest_nxt;
  logic              gap, gap_nxt;
  logic [ADDR_W-1:0] ch_addr [NUM_CH];

  logic              xfer;
  logic [ADDR_W-1:0] hdr_addr;
  logic [REM_W-1:0]  hdr_len;
  logic [REM_W-1:0]  payload_left;
  logic [REM_W-1:0]  drop_left;
  logic              match_hit;
  logic [CH_W-1:0]   match_idx;
  logic [CH_W-1:0]   wr_ch;
  logic [NUM_CH-1:0] fifo_full;
  logic              dest_full;
  logic              wr_en, commit, rollback;

  assign data_in_ack = ~gap;
  assign xfer        = data_in_req & data_in_ack;
  assign hdr_addr    = data_in[HDR_ADDR_LSB +: ADDR_W];
  assign hdr_len     = REM_W'(data_in[DATA_WIDTH-1:LEN_LSB]);
  assign wr_ch       = (state == ST_IDLE) ? match_idx : dest;
  assign dest_full   = fifo_full[wr_ch];

  // Scan downwards so the lowest matching index wins.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_addr[i] == hdr_addr) begin
        match_hit = 1'b1;
        match_idx = CH_W'(i);
      end
    end
  end

`ifdef YAS_ROUTER_CRC_CHECK_EN
  logic [DATA_WIDTH-1:0] crc;

  always_ff @(posedge clk) begin
    if (!rst_n)                           crc <= '0;
    else if (xfer && state == ST_IDLE)    crc <= data_in;
    else if (xfer && state == ST_PAYLOAD) crc <= crc ^ data_in;
  end
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_nxt    = state;
    rem_nxt      = rem;
    dest_nxt     = dest;
    gap_nxt      = 1'b0;
    wr_en        = 1'b0;
    commit       = 1'b0;
    rollback     = 1'b0;
    payload_left = (state == ST_IDLE) ? hdr_len : rem - REM_W'(1);
    drop_left    = payload_left + CRC_EXTRA;
    if (xfer) begin
      case (state)
        ST_IDLE, ST_PAYLOAD: begin
          if (state == ST_IDLE) dest_nxt = match_idx;
          if ((state == ST_PAYLOAD || match_hit) && !dest_full) begin
            wr_en = 1'b1;
            if (payload_left != '0) begin
              state_nxt = ST_PAYLOAD;
              rem_nxt   = payload_left;
            end else begin
`ifdef YAS_ROUTER_CRC_CHECK_EN
              state_nxt = ST_CRC;
`else
              commit    = 1'b1;
              state_nxt = ST_IDLE;
              gap_nxt   = 1'b1;
`endif
            end
          end else begin
            // No destination or destination full: discard what was stored and eat the rest.
            rollback = (state == ST_PAYLOAD) || match_hit;
            if (drop_left == '0) begin
              state_nxt = ST_IDLE;
              gap_nxt   = 1'b1;
            end else begin
              state_nxt = ST_DROP;
              rem_nxt   = drop_left;
            end
          end
        end
        ST_DROP: begin
          if (rem == REM_W'(1)) begin
            state_nxt = ST_IDLE;
            gap_nxt   = 1'b1;
          end else begin
            rem_nxt = rem - REM_W'(1);
          end
        end
`ifdef YAS_ROUTER_CRC_CHECK_EN
        ST_CRC: begin
          commit    = (data_in == crc);
          rollback  = (data_in != crc);
          state_nxt = ST_IDLE;
          gap_nxt   = 1'b1;
        end
`endif
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      rem   <= '0;
      dest  <= '0;
      gap   <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) ch_addr[i] <= ADDR_W'(i);
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      dest  <= dest_nxt;
      gap   <= gap_nxt;
      if (config_en && (int'(config_addr) < NUM_CH)) ch_addr[config_addr] <= config_data;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic sel;
    assign sel = (wr_ch == CH_W'(g));

    yas_fifo_commit #(
      .DATA_WIDTH(DATA_WIDTH),
      .AW        (FIFO_AW)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en & sel),
      .wr_data (data_in),
      .commit  (commit & sel),
      .rollback(rollback & sel),
      .rd_en   (data_out_ack[g]),
      .full    (fifo_full[g]),
      .rd_valid(data_out_req[g]),
      .rd_data (data_out[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_yas_router_n.sv
// Randomized bench for yas_router_n: per-channel expected-byte queues built from the routing rules.
// Honors YAS_ROUTER_CRC_CHECK_EN (adds the trailing XOR byte to every packet).
module tb_yas_router_n;
  localparam int DW    = 8;
  localparam int NCH   = 3;
  localparam int AW    = 2;
  localparam int FAW   = 6;
  localparam int CW    = $clog2(NCH);
  localparam int DEPTH = 1 << FAW;
`ifdef YAS_ROUTER_CRC_CHECK_EN
  localparam int CRC_BYTES = 1;
`else
  localparam int CRC_BYTES = 0;
`endif

  logic              clk         = 1'b0;
  logic              rst_n       = 1'b0;
  logic [DW-1:0]     data_in     = '0;
  logic              data_in_req = 1'b0;
  logic              data_in_ack;
  logic [NCH*DW-1:0] data_out;
  logic [NCH-1:0]    data_out_req;
  logic [NCH-1:0]    data_out_ack = '0;
  logic [CW-1:0]     config_addr  = '0;
  logic [AW-1:0]     config_data  = '0;
  logic              config_en    = 1'b0;

  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] m_addr [NCH];
  logic [DW-1:0] exp_q [NCH][$];
  int            popped [NCH];
  bit            hold0 = 1'b0;
  logic [NCH-1:0] exp_req;

  yas_router_n #(.DATA_WIDTH(DW), .NUM_CH(NCH), .ADDR_W(AW), .FIFO_AW(FAW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .data_in_req (data_in_req),
    .data_in_ack (data_in_ack),
    .data_out    (data_out),
    .data_out_req(data_out_req),
    .data_out_ack(data_out_ack),
    .config_addr (config_addr),
    .config_data (config_data),
    .config_en   (config_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Random consumer; channel 0 can be held off to fill its FIFO.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NCH; i++)
      data_out_ack[i] = !(hold0 && i == 0) && ($urandom_range(0, 3) != 0);
  end

  // Scoreboard: req must mirror "committed bytes pending", and each taken byte must match.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NCH; i++) exp_req[i] = (exp_q[i].size() != 0);
      check("out_req", 32'(data_out_req), 32'(exp_req));
      for (int i = 0; i < NCH; i++) begin
        if (data_out_req[i] && data_out_ack[i] && exp_q[i].size() != 0) begin
          check($sformatf("ch%0d_data", i), 32'(data_out[i*DW +: DW]), 32'(exp_q[i][0]));
          void'(exp_q[i].pop_front());
          popped[i]++;
        end
      end
    end
  end

  function automatic int model_dest(input logic [AW-1:0] a);
    for (int i = 0; i < NCH; i++) if (m_addr[i] == a) return i;
    return -1;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NCH; i++) s += exp_q[i].size();
    return s;
  endfunction

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [DW-1:0] b, output int waits);
    waits       = 0;
    data_in     = b;
    data_in_req = 1'b1;
    @(negedge clk);
    while (!data_in_ack && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    check("ack_timeout", 32'(data_in_ack), 1);
    @(posedge clk);
    #1;
    data_in_req = 1'b0;
  endtask

  task automatic config_write(input logic [CW-1:0] a, input logic [AW-1:0] d);
    config_addr = a;
    config_data = d;
    config_en   = 1'b1;
    @(posedge clk);
    #1;
    config_en = 1'b0;
    if (int'(a) < NCH) m_addr[a] = d;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < NCH; i++) begin
      exp_q[i].delete();
      m_addr[i] = AW'(i);
    end
    check("rst_ack", 32'(data_in_ack), 0);
    check("rst_req", 32'(data_out_req), 0);
    check("rst_data", 32'(data_out), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ack_after_rst", 32'(data_in_ack), 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (pending() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(pending()), 0);
  endtask

  task automatic send_packet(input logic [AW-1:0] addr, input int len, input bit bad_crc,
                             output bit stored);
    logic [DW-1:0] pkt [$];
    logic [DW-1:0] crc;
    int dest, w, hdr_w, body_w;
    pkt.push_back({(DW-AW)'(len), addr});
    for (int j = 0; j < len; j++) pkt.push_back(DW'($urandom));
    crc = '0;
    foreach (pkt[k]) crc ^= pkt[k];
    if (bad_crc) crc ^= DW'($urandom_range(1, 255));
    dest   = model_dest(addr);
    stored = 1'b0;
    if (dest >= 0)
      stored = (exp_q[dest].size() + pkt.size() <= DEPTH) && !(bad_crc && CRC_BYTES != 0);
    send_byte(pkt[0], hdr_w);
    body_w = 0;
    for (int k = 1; k < pkt.size(); k++) begin
      send_byte(pkt[k], w);
      body_w += w;
    end
    if (CRC_BYTES != 0) begin
      send_byte(crc, w);
      body_w += w;
    end
    check("hdr_wait", 32'(hdr_w <= 1), 1);
    check("body_wait", 32'(body_w), 0);
    if (stored) foreach (pkt[k]) exp_q[dest].push_back(pkt[k]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, p0, p1, p2;
    bit st;
    logic [DW-1:0] b1, b2;
    for (int i = 0; i < NCH; i++) popped[i] = 0;

    do_reset(3);

    // Basic routing: header 0x0D -> channel 1, three payload bytes.
    p0 = popped[0]; p1 = popped[1]; p2 = popped[2];
    send_packet(2'd1, 3, 1'b0, st);
    wait_drain();
    check("basic_ch1_cnt", 32'(popped[1] - p1), 4);
    check("basic_others", 32'((popped[0] - p0) + (popped[2] - p2)), 0);

    // Two channels share an address: the lower index takes the packet.
    config_write(2, 2'd1);
    p1 = popped[1]; p2 = popped[2];
    send_packet(2'd1, 1, 1'b0, st);
    wait_drain();
    check("dup_ch1_cnt", 32'(popped[1] - p1), 2 + 0);
    check("dup_ch2_cnt", 32'(popped[2] - p2), 0);
    config_write(2, 2'd2);

    // Unmatched address: bytes consumed, nothing emitted.
    p0 = popped[0]; p1 = popped[1]; p2 = popped[2];
    send_packet(2'd3, 5, 1'b0, st);
    repeat (5) begin @(posedge clk); #1; end
    check("nomatch_out", 32'((popped[0] - p0) + (popped[1] - p1) + (popped[2] - p2)), 0);

    // Reconfiguring mid-packet must not redirect it.
    p1 = popped[1];
    b1 = DW'($urandom);
    b2 = DW'($urandom);
    send_byte({(DW-AW)'(2), 2'd1}, w);
    config_write(1, 2'd3);
    send_byte(b1, w);
    send_byte(b2, w);
    exp_q[1].push_back({(DW-AW)'(2), 2'd1});
    exp_q[1].push_back(b1);
    exp_q[1].push_back(b2);
    wait_drain();
    check("inflight_cnt", 32'(popped[1] - p1), 3);
    config_write(1, 2'd1);
    config_write(3, 2'd0);

    // Fill channel 0: first full-depth packet kept, second dropped whole.
    hold0 = 1'b1;
    p0 = popped[0];
    send_packet(2'd0, DEPTH - 1 - CRC_BYTES, 1'b0, st);
    check("full_first_stored", 32'(st), 1);
    send_packet(2'd0, DEPTH - 1 - CRC_BYTES, 1'b0, st);
    check("full_second_dropped", 32'(st), 0);
    @(negedge clk);
    check("full_head_req", 32'(data_out_req[0]), 1);
    check("full_head_byte", 32'(data_out[DW-1:0]), 32'(exp_q[0][0]));
    @(posedge clk);
    #1;
    hold0 = 1'b0;
    wait_drain();
    check("full_cnt", 32'(popped[0] - p0), DEPTH);
    send_packet(2'd0, 2, 1'b0, st);
    wait_drain();

`ifdef YAS_ROUTER_CRC_CHECK_EN
    // Trailing XOR of 0x04 and 0x55 is 0x51; anything else discards the packet.
    p0 = popped[0];
    send_byte(8'h04, w); send_byte(8'h55, w); send_byte(8'h51, w);
    exp_q[0].push_back(8'h04);
    exp_q[0].push_back(8'h55);
    wait_drain();
    check("crc_good_cnt", 32'(popped[0] - p0), 2);
    p0 = popped[0];
    send_byte(8'h04, w); send_byte(8'h55, w); send_byte(8'h50, w);
    repeat (5) begin @(posedge clk); #1; end
    check("crc_bad_cnt", 32'(popped[0] - p0), 0);
`endif

    // Reset in the middle of a packet discards it; the next packet routes normally.
    send_byte(8'h0D, w);
    send_byte(DW'($urandom), w);
    send_byte(DW'($urandom), w);
    do_reset(1);
    repeat (4) begin @(posedge clk); #1; end
    check("post_rst_req", 32'(data_out_req), 0);
    p1 = popped[1];
    send_packet(2'd1, 3, 1'b0, st);
    wait_drain();
    check("post_rst_cnt", 32'(popped[1] - p1), 4);

    // Random traffic with occasional reconfiguration and bad CRCs.
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      int len, d;
      bit bad;
      if ($urandom_range(0, 4) == 0) config_write(CW'($urandom_range(0, 3)), AW'($urandom));
      a   = AW'($urandom);
      len = $urandom_range(0, 12);
      d   = model_dest(a);
      if (d >= 0 && exp_q[d].size() + len + 1 > DEPTH) wait_drain();
      bad = (CRC_BYTES != 0) && ($urandom_range(0, 3) == 0);
      send_packet(a, len, bad, st);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
